// File: rtl/add_round_key_stream.sv
// AES add-round-key with run-time round-key select and valid/ready handshake.
// Output register plus one skid register gives full throughput under backpressure.
module add_round_key_stream #(
    parameter  int NR    = 10,
    parameter  int BLK_W = 128,
    localparam int RW    = $clog2(NR + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [BLK_W*(NR+1)-1:0]   expanded_key,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [BLK_W-1:0]          in_state,
    input  logic [RW-1:0]             in_round,
    input  logic                      in_decrypt,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [BLK_W-1:0]          out_state,
    output logic [RW-1:0]             out_round,
    output logic                      out_err
);

    logic             or_valid_q, or_valid_d;
    logic [BLK_W-1:0] or_state_q, or_state_d;
    logic [RW-1:0]    or_round_q, or_round_d;
    logic             or_err_q,   or_err_d;

    logic             sk_valid_q, sk_valid_d;
    logic [BLK_W-1:0] sk_state_q, sk_state_d;
    logic [RW-1:0]    sk_round_q, sk_round_d;
    logic             sk_err_q,   sk_err_d;

    logic             key_err;
    logic [RW-1:0]    key_idx;
    logic [BLK_W-1:0] round_key;
    logic [BLK_W-1:0] keyed_state;
    logic             accept;
    logic             or_free;

    // Out-of-range rounds select an all-zero key so the state passes unchanged.
    always_comb begin
        key_err   = (in_round > RW'(NR));
        key_idx   = in_decrypt ? (RW'(NR) - in_round) : in_round;
        round_key = '0;
        for (int r = 0; r <= NR; r++) begin
            if (!key_err && (key_idx == RW'(r))) begin
                round_key = expanded_key[BLK_W*r +: BLK_W];
            end
        end
        keyed_state = in_state ^ round_key;
    end

    assign accept  = in_valid && !sk_valid_q;
    assign or_free = !or_valid_q || out_ready;

    always_comb begin
        or_valid_d = or_valid_q;
        or_state_d = or_state_q;
        or_round_d = or_round_q;
        or_err_d   = or_err_q;
        sk_valid_d = sk_valid_q;
        sk_state_d = sk_state_q;
        sk_round_d = sk_round_q;
        sk_err_d   = sk_err_q;

        if (or_free) begin
            if (sk_valid_q) begin
                or_valid_d = 1'b1;
                or_state_d = sk_state_q;
                or_round_d = sk_round_q;
                or_err_d   = sk_err_q;
                sk_valid_d = 1'b0;
            end else if (accept) begin
                or_valid_d = 1'b1;
                or_state_d = keyed_state;
                or_round_d = in_round;
                or_err_d   = key_err;
            end else begin
                or_valid_d = 1'b0;
            end
        end else if (accept) begin
            sk_valid_d = 1'b1;
            sk_state_d = keyed_state;
            sk_round_d = in_round;
            sk_err_d   = key_err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            or_valid_q <= 1'b0;
            or_state_q <= '0;
            or_round_q <= '0;
            or_err_q   <= 1'b0;
            sk_valid_q <= 1'b0;
            sk_state_q <= '0;
            sk_round_q <= '0;
            sk_err_q   <= 1'b0;
        end else begin
            or_valid_q <= or_valid_d;
            or_state_q <= or_state_d;
            or_round_q <= or_round_d;
            or_err_q   <= or_err_d;
            sk_valid_q <= sk_valid_d;
            sk_state_q <= sk_state_d;
            sk_round_q <= sk_round_d;
            sk_err_q   <= sk_err_d;
        end
    end

    assign in_ready  = !sk_valid_q;
    assign out_valid = or_valid_q;
    assign out_state = or_state_q;
    assign out_round = or_round_q;
    assign out_err   = or_err_q;

endmodule

// File: doc/add_round_key_stream.md
Name: add_round_key_stream

Overview:
- Parametrised successor of the single-cycle add-round-key stage.
- XORs a 128-bit AES state with one round key. The round key is selected at run time from the full expanded key by a per-beat round index, with optional decrypt-order key selection.
- Adds valid/ready handshaking with a 2-entry output skid buffer, so it can sit between the iterative round datapath and the mix-columns stage under backpressure without dropping or duplicating beats.

Parameters:
- NR, 10, number of AES rounds (10/12/14 for AES-128/192/256); expanded key holds NR+1 round keys.
- BLK_W, 128, state and round-key width in bits.
- RW, $clog2(NR+1), round index width (derived; not overridden).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- expanded_key  in  BLK_W*(NR+1)  round key r = expanded_key[BLK_W*r +: BLK_W]; must be stable while in_valid=1.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept an input beat.
- in_state  in  BLK_W  state to be keyed.
- in_round  in  RW  round index 0..NR.
- in_decrypt  in  1  1 = use key index NR-in_round.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_state  out  BLK_W  in_state XOR selected round key.
- out_round  out  RW  in_round carried with the beat.
- out_err  out  1  beat had in_round > NR.

Behaviour:
- Reset (rst_n low, async): out_valid=0, skid_valid=0, in_ready=1, out_state=0, out_round=0, out_err=0. Every register is cleared, including the data registers.
- Accept: in_valid && in_ready on a rising edge.
- Key index: k = in_decrypt ? NR-in_round : in_round.
- Result computed at accept time: in_state ^ expanded_key[BLK_W*k +: BLK_W], then stored. expanded_key is not re-read later.
- Out-of-range: if in_round > NR, the state passes unchanged (XOR with 0), out_err=1 for that beat, and no index wrap. out_err otherwise 0.
- Storage: output register (OR, drives out_*) plus one skid register (SK).
- in_ready = !skid_valid. It is registered, with no combinational path from out_ready.
- Per-cycle update, in priority order:
  - If OR empty, or out_valid && out_ready: OR loads SK if skid_valid (SK is cleared), else OR loads the accepted input if any, else out_valid goes to 0.
  - Else (OR holding and stalled): an accepted input loads SK and skid_valid goes to 1.
- Never accept while SK is full. Since in_ready=0 in that case, no accept can occur.
- Latency: accept at edge N gives out_valid=1 after edge N, i.e. 1 cycle. Throughput is 1 beat/cycle while out_ready=1.
- Ordering: beats leave strictly in acceptance order; SK is always older than any new input.
- Simultaneous: OR drain and input accept in the same cycle with SK empty means the new beat goes straight to OR and out_valid stays 1.
- out_* are stable while out_valid && !out_ready.
- Reset mid-operation discards both OR and SK contents immediately; no partial beat is emitted after rst_n deasserts.
- No X propagation on out_state while out_valid=0; it holds its last value (0 after reset).

Test Plan:
- Encrypt select: NR=10, key slice r = 16 bytes of value r; in_state=0, in_round=1, in_decrypt=0, out_ready=1 -> one cycle later out_valid=1, out_state=0x0101..01, out_round=1, out_err=0.
- Decrypt select: same key, in_state=0xFF..FF, in_round=1, in_decrypt=1 -> out_state=0xF6F6..F6 (slice 9); in_round=0, in_decrypt=1 -> slice 10, out_state=0xF5..F5.
- Backpressure: out_ready=0, push beats A(round 2), B(round 3) back-to-back -> A held in OR, B in SK, in_ready=0 from the cycle after B is accepted; out_ready=1 -> A then B on consecutive cycles, in_ready returns to 1, no loss or duplication.
- Streaming: 11 beats with rounds 0..10, in_valid and out_ready held at 1 -> 11 consecutive outputs in order, in_ready=1 throughout, each out_state equal to its round-byte pattern.
- Out-of-range: in_round=11, in_state=0x0123..CDEF -> out_state unchanged, out_err=1; the next valid beat has out_err=0.
- Async reset: with OR and SK both full, pulse rst_n low mid-cycle -> out_valid=0, in_ready=1 immediately, without waiting for a clock edge; after release, no stale beat appears.
